// File: rtl/wdata_burst_sched.sv
// -----------------------------------------------------------------------------
// wdata_burst_sched
//
// Turns one accepted write-burst command into BURST_LEN fixed-rate DFI
// write-data beats. The first FIFO pop happens WL cycles after the command is
// accepted. Every later cycle of the burst pops one more beat. DFI timing never
// stalls. If the FIFO has no beat in a required slot, that slot is sent as a
// masked zero beat and the sticky underrun flag is set.
//
// Ports
//   clk                 clock
//   rst_n               asynchronous active-low reset
//   wr_cmd_valid_i      request for one write burst
//   wr_cmd_ready_o      block is idle and can take a command (combinational)
//   fifo_rd_ready_i     upstream FIFO has a beat at its head
//   fifo_data_i         FIFO head beat
//   fifo_rd_o           FIFO pop strobe (combinational)
//   dfi_wrdata_en_o     DFI write-data valid (registered)
//   dfi_wrdata_o        DFI write data (registered)
//   dfi_wrdata_mask_o   DFI byte mask, 1 = masked (registered)
//   burst_done_o        one-cycle pulse together with the last DFI beat
//   underrun_o          sticky flag: FIFO was empty in a required beat slot
//   clr_err_i           synchronous clear of underrun_o (a new set wins)
// -----------------------------------------------------------------------------
module wdata_burst_sched #(
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 16,
    parameter int WL        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_cmd_valid_i,
    output logic                  wr_cmd_ready_o,
    input  logic                  fifo_rd_ready_i,
    input  logic [DATA_W-1:0]     fifo_data_i,
    output logic                  fifo_rd_o,
    output logic                  dfi_wrdata_en_o,
    output logic [DATA_W-1:0]     dfi_wrdata_o,
    output logic [DATA_W/8-1:0]   dfi_wrdata_mask_o,
    output logic                  burst_done_o,
    output logic                  underrun_o,
    input  logic                  clr_err_i
);

    localparam int MASK_W    = DATA_W / 8;
    localparam int BEAT_W    = $clog2(BURST_LEN + 1);
    localparam int WAIT_W    = 5;
    // WAIT lasts WL-1 cycles: the counter is loaded with WL-2 and the state
    // moves on when it reads zero.
    localparam int WAIT_LOAD = (WL > 1) ? (WL - 2) : 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [BEAT_W-1:0]   beat_cnt_reg, beat_cnt_next;

    logic                en_reg;
    logic [DATA_W-1:0]   data_reg;
    logic [MASK_W-1:0]   mask_reg;
    logic                done_reg;
    logic                underrun_reg;

    logic                in_stream;
    logic                last_beat;

    assign in_stream = (state_reg == ST_STREAM);
    assign last_beat = (beat_cnt_reg == BEAT_W'(BURST_LEN - 1));

    // While rst_n is low the state is already IDLE. Gating with rst_n also
    // keeps ready low during reset.
    assign wr_cmd_ready_o = (state_reg == ST_IDLE) & rst_n;
    assign fifo_rd_o      = in_stream & fifo_rd_ready_i & rst_n;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (wr_cmd_valid_i) begin
                    beat_cnt_next = '0;
                    if (WL == 1) begin
                        state_next = ST_STREAM;
                    end else begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = WAIT_W'(WAIT_LOAD);
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == '0) begin
                    state_next    = ST_STREAM;
                    beat_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 1'b1;
                end
            end
            ST_STREAM: begin
                // A beat slot is used whether or not the FIFO delivered.
                if (last_beat) begin
                    state_next    = ST_IDLE;
                    beat_cnt_next = '0;
                end else begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = '0;
                beat_cnt_next = '0;
            end
        endcase
    end

    // ---------------------------------------------------------- DFI outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg       <= 1'b0;
            data_reg     <= '0;
            mask_reg     <= '0;
            done_reg     <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            en_reg   <= in_stream;
            done_reg <= in_stream & last_beat;
            if (in_stream && fifo_rd_ready_i) begin
                data_reg <= fifo_data_i;
                mask_reg <= '0;
            end else if (in_stream) begin
                // Missing beat: send a fully masked zero beat in its slot.
                data_reg <= '0;
                mask_reg <= '1;
            end else begin
                data_reg <= '0;
                mask_reg <= '0;
            end
            if (in_stream && !fifo_rd_ready_i) begin
                underrun_reg <= 1'b1;
            end else if (clr_err_i) begin
                underrun_reg <= 1'b0;
            end
        end
    end

    assign dfi_wrdata_en_o   = en_reg;
    assign dfi_wrdata_o      = data_reg;
    assign dfi_wrdata_mask_o = mask_reg;
    assign burst_done_o      = done_reg;
    assign underrun_o        = underrun_reg;

endmodule
